// File: rtl/mdu_divider.sv
// mdu_divider: multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU.
// Optional macro DIV_EARLY_OUT_EN: fast path when |dividend| < |divisor|.
module mdu_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic             ZF,
  output logic             SF
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    SIGN,
    FIN
  } state_e;

  localparam logic [WIDTH-1:0] ONES = '1;
  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH-1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             sgnq_q, sgnq_d;
  logic             sgnr_q, sgnr_d;
  logic             rsel_q, rsel_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zf_q, zf_d;
  logic             sf_q, sf_d;

  logic             is_sgn;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic             b_zero;
  logic             ovf;
  logic             early;
  logic             fast;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  logic [WIDTH-1:0] rem_sh;
  logic [WIDTH:0]   diff;
  logic             fits;
  logic [WIDTH-1:0] q_out;
  logic [WIDTH-1:0] r_out;

  // Operand magnitudes and the results of the single-cycle special cases
  always_comb begin
    is_sgn = ~op[0];
    a_neg  = is_sgn & SrcA[WIDTH-1];
    b_neg  = is_sgn & SrcB[WIDTH-1];
    a_abs  = a_neg ? -SrcA : SrcA;
    b_abs  = b_neg ? -SrcB : SrcB;
    b_zero = (SrcB == '0);
    ovf    = is_sgn & (SrcA == MINV) & (SrcB == ONES);
`ifdef DIV_EARLY_OUT_EN
    early  = ~b_zero & (a_abs < b_abs);
`else
    early  = 1'b0;
`endif
    fast   = b_zero | ovf | early;
    q_fix  = '0;
    r_fix  = SrcA;
    unique case (1'b1)
      b_zero: begin
        q_fix = ONES;
        r_fix = SrcA;
      end
      ovf: begin
        q_fix = MINV;
        r_fix = '0;
      end
      default: begin
        q_fix = '0;
        r_fix = SrcA;
      end
    endcase
  end

  // One restoring step: shift in the next dividend bit, trial subtract
  always_comb begin
    rem_sh = {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
    diff   = {1'b0, rem_sh} - {1'b0, dvs_q};
    fits   = ~diff[WIDTH];
    q_out  = sgnq_q ? -dvd_q : dvd_q;
    r_out  = sgnr_q ? -rem_q : rem_q;
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    sgnq_d  = sgnq_q;
    sgnr_d  = sgnr_q;
    rsel_d  = rsel_q;
    res_d   = res_q;
    zf_d    = zf_q;
    sf_d    = sf_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          rsel_d = op[1];
          if (fast) begin
            res_d   = op[1] ? r_fix : q_fix;
            zf_d    = (res_d == '0);
            sf_d    = res_d[WIDTH-1];
            sgnq_d  = 1'b0;
            sgnr_d  = 1'b0;
            state_d = FIN;
          end else begin
            dvd_d   = a_abs;
            dvs_d   = b_abs;
            rem_d   = '0;
            cnt_d   = '0;
            sgnq_d  = a_neg ^ b_neg;
            sgnr_d  = a_neg;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        busy  = 1'b1;
        rem_d = fits ? diff[WIDTH-1:0] : rem_sh;
        dvd_d = {dvd_q[WIDTH-2:0], fits};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = SIGN;
        end
      end
      SIGN: begin
        busy    = 1'b1;
        dvd_d   = q_out;
        rem_d   = r_out;
        res_d   = rsel_q ? r_out : q_out;
        zf_d    = (res_d == '0);
        sf_d    = res_d[WIDTH-1];
        state_d = FIN;
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      sgnq_q  <= 1'b0;
      sgnr_q  <= 1'b0;
      rsel_q  <= 1'b0;
      res_q   <= '0;
      zf_q    <= 1'b1;
      sf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      sgnq_q  <= sgnq_d;
      sgnr_q  <= sgnr_d;
      rsel_q  <= rsel_d;
      res_q   <= res_d;
      zf_q    <= zf_d;
      sf_q    <= sf_d;
    end
  end

  assign Result = res_q;
  assign ZF     = zf_q;
  assign SF     = sf_q;

endmodule

// File: tb/tb_mdu_divider.sv
// tb_mdu_divider: random and directed checks of mdu_divider
// against an arithmetic RV32M reference model.
module tb_mdu_divider;

  localparam logic [31:0] MINV = 32'h8000_0000;
  localparam logic [31:0] ONES = 32'hFFFF_FFFF;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        busy;
  logic        done;
  logic [31:0] res;
  logic        zf;
  logic        sf;

  int checks = 0;
  int errors = 0;

  mdu_divider dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op_i),
    .SrcA   (a_i),
    .SrcB   (b_i),
    .busy   (busy),
    .done   (done),
    .Result (res),
    .ZF     (zf),
    .SF     (sf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_div(input logic [1:0] o,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa;
    longint sb;
    if (b == 0) return o[1] ? a : ONES;
    if (!o[0]) begin
      if (a == MINV && b == ONES) return o[1] ? 32'h0 : MINV;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return o[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return o[1] ? (a % b) : (a / b);
  endfunction

  function automatic int exp_lat(input logic [1:0] o,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
    logic [31:0] ma;
    logic [31:0] mb;
`endif
    if (b == 0) return 1;
    if (!o[0] && a == MINV && b == ONES) return 1;
`ifdef DIV_EARLY_OUT_EN
    ma = (!o[0] && a[31]) ? -a : a;
    mb = (!o[0] && b[31]) ? -b : b;
    if (ma < mb) return 1;
`endif
    return 34;
  endfunction

  // wait for done, sampling on negedges; n counts cycles from start
  task automatic wait_done(output int n);
    n = 1;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic do_op(input string tag, input logic [1:0] o,
                       input logic [31:0] a, input logic [31:0] b);
    logic [31:0] e;
    int n;
    e = ref_div(o, a, b);
    @(negedge clk);
    op_i  = o;
    a_i   = a;
    b_i   = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a_i   = $urandom;
    b_i   = $urandom;
    op_i  = 2'($urandom);
    wait_done(n);
    chk({tag, "_lat"}, 32'(n), 32'(exp_lat(o, a, b)));
    chk({tag, "_res"}, res, e);
    chk({tag, "_zf"}, {31'b0, zf}, {31'b0, e == 0});
    chk({tag, "_sf"}, {31'b0, sf}, {31'b0, e[31]});
    @(negedge clk);
    chk({tag, "_pulse"}, {31'b0, done}, 32'h0);
    chk({tag, "_hold"}, res, e);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n;
    int cnt;
    int first;
    logic [1:0]  o;
    logic [31:0] a;
    logic [31:0] b;

    rst_n = 1'b0;
    start = 1'b0;
    op_i  = 2'b00;
    a_i   = '0;
    b_i   = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    chk("rst_res", res, 32'h0);
    chk("rst_zf", {31'b0, zf}, 32'h1);
    chk("rst_sf", {31'b0, sf}, 32'h0);
    rst_n = 1'b1;

    do_op("divu_100_7", 2'b01, 32'd100, 32'd7);
    do_op("remu_100_7", 2'b11, 32'd100, 32'd7);
    do_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2);
    do_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2);
    do_op("divu_z", 2'b01, 32'd5, 32'd0);
    do_op("remu_z", 2'b11, 32'd5, 32'd0);
    do_op("div_z", 2'b00, 32'hFFFF_FFF0, 32'd0);
    do_op("rem_z", 2'b10, 32'hFFFF_FFF0, 32'd0);
    do_op("div_ovf", 2'b00, MINV, ONES);
    do_op("rem_ovf", 2'b10, MINV, ONES);
    do_op("divu_big", 2'b01, ONES, 32'hFFFF_FFFE);
    do_op("div_small", 2'b00, 32'd3, 32'hFFFF_FF00);
    do_op("rem_small", 2'b10, 32'hFFFF_FFFD, 32'd100);

    // reset in the middle of an iteration
    @(negedge clk);
    op_i  = 2'b01;
    a_i   = 32'd123456;
    b_i   = 32'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'b0, busy}, 32'h0);
    chk("abort_done", {31'b0, done}, 32'h0);
    chk("abort_res", res, 32'h0);
    chk("abort_zf", {31'b0, zf}, 32'h1);
    cnt = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (done) cnt++;
    end
    chk("abort_nodone", 32'(cnt), 32'h0);
    do_op("after_rst", 2'b01, 32'd123456, 32'd3);

    // start while busy is ignored
    @(negedge clk);
    op_i  = 2'b01;
    a_i   = 32'd1000;
    b_i   = 32'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt   = 0;
    first = 0;
    for (int c = 1; c <= 60; c++) begin
      if (done) begin
        cnt++;
        if (first == 0) first = c;
      end
      if (c == 5) begin
        start = 1'b1;
        op_i  = 2'b11;
        a_i   = 32'd9;
        b_i   = 32'd4;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    chk("busy_start_cnt", 32'(cnt), 32'h1);
    chk("busy_start_lat", 32'(first), 32'd34);
    chk("busy_start_res", res, 32'd333);

    // start during done ignored, accepted in the following idle cycle
    @(negedge clk);
    op_i  = 2'b01;
    a_i   = 32'd1000;
    b_i   = 32'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    chk("fin_first", res, 32'd333);
    op_i  = 2'b00;
    a_i   = -32'sd1000;
    b_i   = 32'd7;
    start = 1'b1;
    @(negedge clk);
    chk("fin_ign_busy", {31'b0, busy}, 32'h0);
    chk("fin_ign_done", {31'b0, done}, 32'h0);
    chk("fin_ign_res", res, 32'd333);
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    chk("fin_next_lat", 32'(n), 32'd34);
    chk("fin_next_res", res, 32'hFFFF_FF72);

    // randomized operations
    for (int i = 0; i < 60; i++) begin
      o = 2'($urandom);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: ;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'h0;
        3: begin
          a = MINV;
          b = ($urandom_range(0, 1) == 1) ? ONES : 32'd1;
        end
        4: begin
          a = 32'($urandom_range(0, 200));
          b = $urandom | 32'h0000_1000;
        end
        default: begin
          a = -32'($urandom_range(1, 5000));
          b = -32'($urandom_range(1, 50));
        end
      endcase
      do_op($sformatf("rnd%0d", i), o, a, b);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
